// File: rtl/player_move_fsm_if.sv
// Request, wall-RAM and status bundle between the key decoder / maze RAM and player_move_fsm.
interface player_move_fsm_if;
  logic        move_req;
  logic [1:0]  move_dir;
  logic        wall_q;
  logic [14:0] mem_addr;
  logic [7:0]  player_x;
  logic [6:0]  player_y;
  logic        doneChangePosition;
  logic        blocked;
  logic        busy;
  logic        exit_reached;

  modport master (
    output move_req, move_dir, wall_q,
    input  mem_addr, player_x, player_y, doneChangePosition, blocked, busy, exit_reached
  );

  modport slave (
    input  move_req, move_dir, wall_q,
    output mem_addr, player_x, player_y, doneChangePosition, blocked, busy, exit_reached
  );
endinterface

// File: rtl/player_move_fsm.sv
// Player token mover: bound check, wall-RAM lookup, commit with cooldown, sticky exit flag.
module player_move_fsm #(
  parameter int unsigned BOARD_W    = 160,
  parameter int unsigned BOARD_H    = 120,
  parameter int unsigned START_X    = 1,
  parameter int unsigned START_Y    = 1,
  parameter int unsigned EXIT_X     = 158,
  parameter int unsigned EXIT_Y     = 118,
  parameter int unsigned MOVE_DELAY = 2500000
) (
  input logic              clock,
  input logic              resetn,
  player_move_fsm_if.slave bus
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned AW = 15;
  localparam int unsigned CW = 22;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_WAIT, S_CHECK, S_REJECT, S_COOLDOWN
  } state_e;

  state_e          state_q;
  logic [1:0]      dir_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic [AW-1:0]   addr_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;
  logic            blocked_q;
  logic            busy_q;
  logic            exit_q;

  logic [XW:0]     cand_x_d;
  logic [YW:0]     cand_y_d;
  logic            cand_oob_d;
  logic            cand_exit_d;
  logic [AW-1:0]   addr_d;

  // Candidate in one extra bit so x-1 at 0 becomes all-ones and fails the bound test
  always_comb begin
    cand_x_d = (XW+1)'(x_q);
    cand_y_d = (YW+1)'(y_q);
    case (dir_q)
      2'b00:   cand_y_d = (YW+1)'(y_q) - (YW+1)'(1);
      2'b01:   cand_y_d = (YW+1)'(y_q) + (YW+1)'(1);
      2'b10:   cand_x_d = (XW+1)'(x_q) - (XW+1)'(1);
      default: cand_x_d = (XW+1)'(x_q) + (XW+1)'(1);
    endcase
    cand_oob_d  = (cand_x_d >= (XW+1)'(BOARD_W)) || (cand_y_d >= (YW+1)'(BOARD_H));
    cand_exit_d = (cand_x_d == (XW+1)'(EXIT_X)) && (cand_y_d == (YW+1)'(EXIT_Y));
    addr_d      = AW'(cand_y_d) * AW'(BOARD_W) + AW'(cand_x_d);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      dir_q     <= 2'b00;
      x_q       <= XW'(START_X);
      y_q       <= YW'(START_Y);
      addr_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
      busy_q    <= 1'b0;
      exit_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.move_req && !exit_q) begin
            dir_q   <= bus.move_dir;
            state_q <= S_CALC;
            busy_q  <= 1'b1;
          end
        end
        S_CALC: begin
          if (cand_oob_d) begin
            state_q <= S_REJECT;
          end else begin
            addr_q  <= addr_d;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: state_q <= S_CHECK;
        S_CHECK: begin
          if (bus.wall_q) begin
            state_q <= S_REJECT;
          end else begin
            x_q    <= cand_x_d[XW-1:0];
            y_q    <= cand_y_d[YW-1:0];
            done_q <= 1'b1;
            cnt_q  <= CW'(MOVE_DELAY);
            if (cand_exit_d) exit_q <= 1'b1;
            if (MOVE_DELAY == 0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_COOLDOWN;
            end
          end
        end
        S_REJECT: begin
          blocked_q <= 1'b1;
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
        end
        S_COOLDOWN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr           = addr_q;
  assign bus.player_x           = x_q;
  assign bus.player_y           = y_q;
  assign bus.doneChangePosition = done_q;
  assign bus.blocked            = blocked_q;
  assign bus.busy               = busy_q;
  assign bus.exit_reached       = exit_q;

endmodule
